// File: rtl/spart_pkg.sv
// spart_pkg: constants shared by the SPART processor-side bus interface.
// Holds the register address map, status bit positions and control bit
// positions used by the bus decode and by anything reading the registers.
package spart_pkg;

   // Register select values on IOADDR
   localparam logic [1:0] ADDR_DATA   = 2'b00;
   localparam logic [1:0] ADDR_STATUS = 2'b01;
   localparam logic [1:0] ADDR_DB_LO  = 2'b10;
   localparam logic [1:0] ADDR_DB_HI  = 2'b11;

   // Status register bit positions, LSB first
   localparam int ST_RDA     = 0;
   localparam int ST_TBR     = 1;
   localparam int ST_RXOVR   = 2;
   localparam int ST_TXEMPTY = 3;
   localparam int ST_TXOVF   = 4;

   // Control register bit positions
   localparam int CTL_RXIE = 0;
   localparam int CTL_TXIE = 1;

endpackage

// File: rtl/spart_fifo.sv
// spart_fifo: synchronous FIFO used for both the SPART receive and transmit
// buffers. A push into a full FIFO is accepted when a pop happens on the same
// edge. The head reads 0 whenever the FIFO is empty.
//
// Ports:
//   clk    in  1      system clock
//   rst_n  in  1      asynchronous active-low reset (empties the FIFO)
//   push   in  1      write wdata this edge (ignored when full without a pop)
//   wdata  in  WIDTH  data to push
//   pop    in  1      drop the head this edge (ignored when empty)
//   full   out 1      DEPTH entries held
//   empty  out 1      no entries held
//   head   out WIDTH  oldest entry, 0 when empty
module spart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit to tell full from empty.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             pop_do;
   logic             push_do;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_do  = pop & ~empty;
   assign push_do = push & (~full | pop_do);
   assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_do) wr_ptr <= wr_ptr + 1'b1;
         if (pop_do)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage is not reset; the empty gating on head hides stale contents.
   always_ff @(posedge clk) begin
      if (push_do) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/spart_bus_fifo_if.sv
// spart_bus_fifo_if: processor-side bus interface of the SPART. Decodes the
// shared tri-state data bus into an RX FIFO (read 00), a TX FIFO (write 00),
// status/control (01) and the two-byte baud divisor (10 low, 11 high). Keeps
// sticky RX-overrun / TX-overflow flags and a registered interrupt request.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   IOCS, IORW       chip select (one cycle = one access), 1 = read
//   IOADDR           register select
//   DATABUS          shared bus, driven only while IOCS & IORW
//   rx_valid/rx_data received character strobe from the receiver
//   tx_valid/tx_data TX FIFO head offered to the transmitter
//   tx_ready         transmitter takes the head this cycle
//   divisor          {DB_HIGH, DB_LOW} to the baud-rate generator
//   brg_load         one-cycle pulse after a DB_HIGH write
//   irq              registered interrupt request
module spart_bus_fifo_if
   import spart_pkg::*;
#(
   parameter int          DATA_W     = 8,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] DIV_RESET  = 16'h0145
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              IOCS,
   input  logic              IORW,
   input  logic [1:0]        IOADDR,
   inout  wire  [DATA_W-1:0] DATABUS,
   input  logic              rx_valid,
   input  logic [DATA_W-1:0] rx_data,
   output logic              tx_valid,
   output logic [DATA_W-1:0] tx_data,
   input  logic              tx_ready,
   output logic [15:0]       divisor,
   output logic              brg_load,
   output logic              irq
);

   // Byte <-> bus conversion: zero-extend above bit 7, truncate when narrower.
   function automatic logic [DATA_W-1:0] byte_to_bus(input logic [7:0] b);
      logic [DATA_W-1:0] r;
      r = '0;
      for (int i = 0; i < DATA_W; i++) begin
         if (i < 8) r[i] = b[i];
      end
      return r;
   endfunction

   function automatic logic [7:0] bus_to_byte(input logic [DATA_W-1:0] d);
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         if (i < DATA_W) r[i] = d[i];
      end
      return r;
   endfunction

   logic              rd_access;
   logic              wr_access;
   logic              rx_pop;
   logic              tx_push;
   logic              tx_pop;
   logic              rx_full;
   logic              rx_empty;
   logic              tx_full;
   logic              tx_empty;
   logic [DATA_W-1:0] rx_head;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] status;
   logic [DATA_W-1:0] rd_data;
   logic              rx_overrun;
   logic              tx_overflow;
   logic              status_clr;
   logic              rx_ovr_set;
   logic              tx_ovf_set;
   logic [1:0]        ctrl;
   logic [7:0]        db_lo;
   logic [7:0]        db_hi;

   assign rd_access = IOCS & IORW;
   assign wr_access = IOCS & ~IORW;
   assign wr_data   = DATABUS;

   assign rx_pop     = rd_access && (IOADDR == ADDR_DATA);
   assign tx_push    = wr_access && (IOADDR == ADDR_DATA);
   assign tx_pop     = tx_valid & tx_ready;
   assign status_clr = rd_access && (IOADDR == ADDR_STATUS);

   // A pop on the same edge frees a slot, so the incoming entry is not lost.
   // rx_full implies non-empty, so rx_pop really pops here.
   assign rx_ovr_set = rx_valid & rx_full & ~rx_pop;
   assign tx_ovf_set = tx_push & tx_full & ~tx_pop;

   spart_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rx_valid),
      .wdata (rx_data),
      .pop   (rx_pop),
      .full  (rx_full),
      .empty (rx_empty),
      .head  (rx_head)
   );

   spart_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (tx_push),
      .wdata (wr_data),
      .pop   (tx_pop),
      .full  (tx_full),
      .empty (tx_empty),
      .head  (tx_data)
   );

   assign tx_valid = ~tx_empty;
   assign divisor  = {db_hi, db_lo};

   always_comb begin
      status             = '0;
      status[ST_RDA]     = ~rx_empty;
      status[ST_TBR]     = ~tx_full;
      status[ST_RXOVR]   = rx_overrun;
      status[ST_TXEMPTY] = tx_empty;
      status[ST_TXOVF]   = tx_overflow;
   end

   always_comb begin
      rd_data = '0;
      case (IOADDR)
         ADDR_DATA:   rd_data = rx_head;
         ADDR_STATUS: rd_data = status;
         ADDR_DB_LO:  rd_data = byte_to_bus(db_lo);
         ADDR_DB_HI:  rd_data = byte_to_bus(db_hi);
         default:     rd_data = '0;
      endcase
   end

   assign DATABUS = rd_access ? rd_data : {DATA_W{1'bz}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_overrun  <= 1'b0;
         tx_overflow <= 1'b0;
         ctrl        <= '0;
         db_lo       <= DIV_RESET[7:0];
         db_hi       <= DIV_RESET[15:8];
         brg_load    <= 1'b0;
         irq         <= 1'b0;
      end else begin
         // Set wins over the clear from a coincident status read.
         rx_overrun  <= rx_ovr_set | (rx_overrun & ~status_clr);
         tx_overflow <= tx_ovf_set | (tx_overflow & ~status_clr);
         if (wr_access && (IOADDR == ADDR_STATUS)) begin
            ctrl[CTL_RXIE] <= wr_data[CTL_RXIE];
            ctrl[CTL_TXIE] <= wr_data[CTL_TXIE];
         end
         if (wr_access && (IOADDR == ADDR_DB_LO)) db_lo <= bus_to_byte(wr_data);
         if (wr_access && (IOADDR == ADDR_DB_HI)) db_hi <= bus_to_byte(wr_data);
         brg_load <= wr_access && (IOADDR == ADDR_DB_HI);
         irq      <= (ctrl[CTL_RXIE] & ~rx_empty) | (ctrl[CTL_TXIE] & tx_empty);
      end
   end

endmodule

// File: tb/tb_spart_bus_fifo_if.sv
module tb_spart_bus_fifo_if;

   localparam int DW    = 8;
   localparam int DEPTH = 4;

   logic          clk;
   logic          rst_n;
   logic          IOCS;
   logic          IORW;
   logic [1:0]    IOADDR;
   wire  [DW-1:0] DATABUS;
   logic          rx_valid;
   logic [DW-1:0] rx_data;
   logic          tx_valid;
   logic [DW-1:0] tx_data;
   logic          tx_ready;
   logic [15:0]   divisor;
   logic          brg_load;
   logic          irq;

   logic          tb_oe;
   logic [DW-1:0] tb_dout;

   int vectors;
   int miscompares;

   // Scoreboards: expected RX read-back order and expected TX head order
   logic [DW-1:0] rx_q[$];
   logic [DW-1:0] tx_q[$];
   logic          m_rx_ovr;
   logic          m_tx_ovf;

   assign DATABUS = tb_oe ? tb_dout : {DW{1'bz}};

   spart_bus_fifo_if #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .DIV_RESET(16'h0145)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .IOCS     (IOCS),
      .IORW     (IORW),
      .IOADDR   (IOADDR),
      .DATABUS  (DATABUS),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_ready (tx_ready),
      .divisor  (divisor),
      .brg_load (brg_load),
      .irq      (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected status from the bench model
   function automatic logic [7:0] model_status();
      logic [7:0] s;
      s    = 8'h00;
      s[0] = (rx_q.size() != 0);
      s[1] = (tx_q.size() < DEPTH);
      s[2] = m_rx_ovr;
      s[3] = (tx_q.size() == 0);
      s[4] = m_tx_ovf;
      return s;
   endfunction

   // Tasks start and end 1 time unit after a rising edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_read(input logic [1:0] addr, output logic [DW-1:0] d);
      IOCS = 1'b1; IORW = 1'b1; IOADDR = addr;
      #2;
      d = DATABUS;
      next_cycle();
      IOCS = 1'b0; IORW = 1'b0;
   endtask

   task automatic bus_write(input logic [1:0] addr, input logic [DW-1:0] d);
      IOCS = 1'b1; IORW = 1'b0; IOADDR = addr;
      tb_oe = 1'b1; tb_dout = d;
      next_cycle();
      IOCS = 1'b0; tb_oe = 1'b0;
   endtask

   task automatic rx_strobe(input logic [DW-1:0] d);
      rx_valid = 1'b1; rx_data = d;
      if (rx_q.size() < DEPTH) rx_q.push_back(d);
      else m_rx_ovr = 1'b1;
      next_cycle();
      rx_valid = 1'b0;
   endtask

   task automatic status_read(input string tag);
      logic [DW-1:0] d;
      logic [7:0]    e;
      e = model_status();
      bus_read(2'b01, d);
      check(tag, {8'h00, d}, {8'h00, e});
      m_rx_ovr = 1'b0;
      m_tx_ovf = 1'b0;
   endtask

   task automatic data_read(input string tag);
      logic [DW-1:0] d;
      logic [DW-1:0] e;
      e = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
      bus_read(2'b00, d);
      check(tag, {8'h00, d}, {8'h00, e});
   endtask

   task automatic tx_write(input logic [DW-1:0] d);
      // A head handed over on the same edge makes room for this push.
      if (tx_valid && tx_ready && tx_q.size() != 0) void'(tx_q.pop_front());
      if (tx_q.size() < DEPTH) tx_q.push_back(d);
      else m_tx_ovf = 1'b1;
      bus_write(2'b00, d);
   endtask

   initial begin
      logic [DW-1:0] d;
      logic [DW-1:0] zz;
      vectors = 0; miscompares = 0;
      m_rx_ovr = 1'b0; m_tx_ovf = 1'b0;
      rst_n = 1'b0; IOCS = 1'b0; IORW = 1'b0; IOADDR = 2'b00;
      rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
      tb_oe = 1'b0; tb_dout = '0;
      zz = {DW{1'bz}};

      // ---- reset state ----
      repeat (3) next_cycle();
      check("rst_tx_valid", {15'd0, tx_valid}, 16'h0000);
      check("rst_tx_data",  {8'h00, tx_data},  16'h0000);
      check("rst_irq",      {15'd0, irq},      16'h0000);
      check("rst_brg_load", {15'd0, brg_load}, 16'h0000);
      check("rst_divisor",  divisor,           16'h0145);
      rst_n = 1'b1;
      next_cycle();
      vectors++;
      assert (DATABUS === zz) else begin
         miscompares++;
         $error("FAIL databus_hiz observed=%h expected=%h", DATABUS, zz);
      end
      status_read("status_after_reset");

      // ---- RX overrun with five strobes into a four-deep FIFO ----
      for (int i = 0; i < 5; i++) rx_strobe(8'h11 + 8'(i));
      status_read("status_rx_overrun");
      status_read("status_overrun_cleared");
      for (int i = 0; i < 5; i++) data_read($sformatf("rx_read_%0d", i));

      // ---- TX handshake ----
      tx_write(8'hA5);
      tx_write(8'h5A);
      check("tx_valid_loaded", {15'd0, tx_valid}, 16'h0001);
      check("tx_head_first",   {8'h00, tx_data},  {8'h00, tx_q[0]});
      tx_ready = 1'b1;
      next_cycle();
      void'(tx_q.pop_front());
      check("tx_head_second", {8'h00, tx_data}, {8'h00, tx_q[0]});
      next_cycle();
      void'(tx_q.pop_front());
      check("tx_valid_drained", {15'd0, tx_valid}, 16'h0000);
      tx_ready = 1'b0;

      // ---- divisor ----
      bus_write(2'b10, 8'h34);
      check("brg_after_lo", {15'd0, brg_load}, 16'h0000);
      check("div_after_lo", divisor, 16'h0134);
      bus_write(2'b11, 8'h12);
      check("brg_after_hi", {15'd0, brg_load}, 16'h0001);
      check("div_after_hi", divisor, 16'h1234);
      next_cycle();
      check("brg_one_cycle", {15'd0, brg_load}, 16'h0000);
      bus_read(2'b10, d);
      check("db_lo_read", {8'h00, d}, 16'h0034);
      bus_read(2'b11, d);
      check("db_hi_read", {8'h00, d}, 16'h0012);

      // ---- RX interrupt ----
      bus_write(2'b01, 8'h01);
      next_cycle();
      check("irq_idle", {15'd0, irq}, 16'h0000);
      rx_strobe(8'h7E);
      check("irq_one_edge", {15'd0, irq}, 16'h0000);
      next_cycle();
      check("irq_two_edges", {15'd0, irq}, 16'h0001);
      data_read("rx_irq_data");
      check("irq_at_pop", {15'd0, irq}, 16'h0001);
      next_cycle();
      check("irq_after_pop", {15'd0, irq}, 16'h0000);
      bus_write(2'b01, 8'h00);

      // ---- TX full boundary: push with concurrent pop, then overflow ----
      for (int i = 0; i < DEPTH; i++) tx_write(8'hC0 + 8'(i));
      status_read("status_tx_full");
      tx_ready = 1'b1;
      tx_write(8'hC4);
      tx_ready = 1'b0;
      check("tx_head_after_swap", {8'h00, tx_data}, {8'h00, tx_q[0]});
      status_read("status_no_overflow");
      tx_write(8'hC5);
      status_read("status_tx_overflow");
      status_read("status_overflow_cleared");

      // ---- mid-operation reset ----
      rx_strobe(8'h42);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_tx_valid", {15'd0, tx_valid}, 16'h0000);
      check("midrst_divisor",  divisor, 16'h0145);
      rx_q.delete(); tx_q.delete();
      m_rx_ovr = 1'b0; m_tx_ovf = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      status_read("status_after_midrst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Overall time bound so the run can never hang.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/spart_bus_fifo_if.md
# spart_bus_fifo_if

Parametrised processor-side bus interface for the SPART. It decodes the shared tri-state data bus into a receive FIFO, a transmit FIFO, a status register, an interrupt-control register and a two-byte baud divisor. It sits between the processor bus and the SPART receiver, transmitter and baud-rate generator. Unlike the single-buffer interface it replaces, it buffers both directions, reports sticky error flags, makes the divisor readable and generates an interrupt.

## Interface
- DATA_W, 8: bus and character width; must be ≥ 6.
- FIFO_DEPTH, 4: entries per FIFO; power of two, ≥ 2.
- DIV_RESET, 16'h0145: divisor value after reset.
- clk  in  1: system clock; all state updates on the rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- IOCS  in  1: chip select; one cycle high = one access.
- IORW  in  1: 1 = processor read, 0 = processor write.
- IOADDR  in  2: register select.
- DATABUS  inout  DATA_W: shared bus; driven only while IOCS & IORW, else high-Z.
- rx_valid  in  1: one-cycle strobe, received character available.
- rx_data  in  DATA_W: received character, valid with rx_valid.
- tx_valid  out  1: TX FIFO non-empty.
- tx_data  out  DATA_W: TX FIFO head.
- tx_ready  in  1: transmitter accepts the head this cycle.
- divisor  out  16: baud divisor {DB_HIGH, DB_LOW}.
- brg_load  out  1: one-cycle pulse, divisor just updated.
- irq  out  1: registered interrupt request.

## Operation
- Address map:
  - 00 read pops the RX FIFO; 00 write pushes the TX FIFO.
  - 01 read returns status; 01 write sets control.
  - 10 reads or writes DB_LOW.
  - 11 reads or writes DB_HIGH.
- Status, LSB first: RDA (RX non-empty), TBR (TX not full), rx_overrun, tx_empty, tx_overflow. Remaining bits read 0.
- Status read clears rx_overrun and tx_overflow at the end of the access cycle. The value read shows the pre-clear state.
- Control bit0 = rx_irq_en, bit1 = tx_irq_en. Other bits are ignored on write and read back as 0 through status only; control itself is write-only.
- irq next = (rx_irq_en & RDA) | (tx_irq_en & tx_empty).
- Read of an empty RX FIFO returns 0 and moves no pointer.
- Writing 00 when the TX FIFO is full drops the data and sets tx_overflow.
- rx_valid when the RX FIFO is full drops the character and sets rx_overrun.
- Simultaneous RX pop and rx_valid on a full FIFO: both happen, no overrun. The same rule applies to a TX push and tx_ready on a full FIFO.
- Simultaneous error set and status-read clear: the set wins and the flag stays 1.
- Writing DB_LOW updates only the low byte; no pulse.
- Writing DB_HIGH updates the high byte; brg_load pulses for one cycle.
- Divisor reads return the current byte; bits above 8 are zero-extended when DATA_W > 8.
- TX handshake: the head is popped on an edge where tx_valid & tx_ready.

## Timing
- Reset values:
  - Both FIFOs empty; tx_valid = 0; tx_data = 0.
  - Flags 0; control 0; irq 0; brg_load 0.
  - divisor = DIV_RESET; DATABUS high-Z.
- Read data is combinational within the access cycle. Pops and flag clears take effect at that cycle's closing edge.
- Write data is sampled at the closing edge of the access cycle.
- rx_valid at edge N gives RDA = 1 from cycle N+1.
- irq lags the status change by one cycle.
- brg_load and the new divisor both appear on the edge that closes the DB_HIGH write.
- Holding IOCS high for k cycles performs k accesses; this is legal and used by tests.
- rst_n asserted mid-operation immediately empties the FIFOs and restores all reset values. No partial access completes.

## Structure
- Shared package spart_pkg holds:
  - address constants ADDR_DATA, ADDR_STATUS, ADDR_DB_LO, ADDR_DB_HI;
  - status bit indices ST_RDA, ST_TBR, ST_RXOVR, ST_TXEMPTY, ST_TXOVF;
  - control bit indices CTL_RXIE, CTL_TXIE.
- Sub-module spart_fifo (params WIDTH, DEPTH) provides push, pop, full, empty and head, with simultaneous push/pop allowed when full. It is instantiated once for RX and once for TX.
- The top level holds decode, flags, control, divisor and irq.

## Test plan
- Reset, then status read → 8'h0A (TBR, tx_empty). divisor = 16'h0145; DATABUS high-Z with IOCS = 0.
- Five rx_valid strobes 0x11–0x15 with depth 4:
  - status read → 8'h0F (RDA, TBR, rx_overrun, tx_empty); second status read → 8'h0B;
  - four data reads → 0x11, 0x12, 0x13, 0x14; fifth read → 0x00.
- Write 0xA5 and 0x5A to 00 with tx_ready = 0 → tx_valid = 1, tx_data = 0xA5. Raise tx_ready for 2 cycles → 0x5A is presented, then tx_valid = 0.
- Write 0x34 to 10, then 0x12 to 11 → divisor = 16'h1234, with brg_load high for exactly one cycle after the second write only. Reads of 10 and 11 → 0x34, 0x12.
- Write control 0x01, then rx_valid 0x7E → irq high two edges after the rx_valid edge. Data read → irq low one cycle after the pop.
- Fill the TX FIFO and push a fifth byte in the same cycle as tx_ready → no tx_overflow. Push again with tx_ready = 0 → tx_overflow set.
